// File: rtl/alu4_pkg.sv
// Shared constants and types for the alu4 datapath and its command sequencer.
package alu4_pkg;

  // alu4 opcodes, carried in cmd_op[2:0]
  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b111;

  // cmd_op[LOADI_BIT]=1 selects "load immediate" instead of an ALU op
  localparam int LOADI_BIT = 3;

  // Bit positions inside the {c,n,z,v} flag register
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    WB    = 2'b11
  } state_e;

endpackage

// File: rtl/alu4.sv
// 4-bit combinational ALU. Arithmetic ops report carry-out and signed
// overflow; logic ops leave c and v at 0. n and z always describe y.
module alu4
  import alu4_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] y,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);

  logic [4:0] sum;

  // Opcode decode and flag generation; subtract is a + ~b + 1 so c means "no borrow".
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    sum = 5'd0;
    y   = 4'd0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_NOTA: y = ~a;
      OP_NOTB: y = ~b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
        y   = sum[3:0];
        c   = sum[4];
        v   = (a[3] != b[3]) && (y[3] != a[3]);
      end
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[3:0];
        c   = sum[4];
        v   = (a[3] == b[3]) && (y[3] != a[3]);
      end
      default: y = 4'd0;
    endcase
    n = y[3];
    z = (y == 4'd0);
  end

endmodule

// File: rtl/regfile4.sv
// NREG x 4-bit register file: one synchronous write port, three
// combinational read ports (operand a, operand b, debug).
module regfile4 #(
  parameter int NREG = 4,
  parameter int RAW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [3:0]     wdata,
  input  logic [RAW-1:0] ra_addr,
  output logic [3:0]     ra_data,
  input  logic [RAW-1:0] rb_addr,
  output logic [3:0]     rb_data,
  input  logic [RAW-1:0] rd_addr,
  output logic [3:0]     rd_data
);

  logic [3:0] mem_q [NREG];
  logic [3:0] mem_d [NREG];

  // Next-state of the array: copy, then overlay the single write.
  always_comb begin
    // NOTE: always_comb uses blocking '=' so the overlay below sees the copy;
    // the flop update in always_ff uses non-blocking '<=' only.
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage; the whole array clears on reset.
  always_ff @(posedge clk) begin
    // NOTE: this array is reset on purpose because every register must read
    // 0000 after reset; that keeps it out of RAM macros, which is fine at 4x4.
    if (reset) mem_q <= '{default: 4'd0};
    else       mem_q <= mem_d;
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu4_ctrl.sv
// Command sequencer around one alu4: IDLE accepts a command, FETCH reads
// operands, EXEC captures the ALU outputs, WB writes register, result, flags.
module alu4_ctrl
  import alu4_pkg::*;
#(
  parameter int NREG = 4,
  parameter int RAW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [3:0]     cmd_op,
  input  logic [RAW-1:0] cmd_dst,
  input  logic [RAW-1:0] cmd_sa,
  input  logic [RAW-1:0] cmd_sb,
  input  logic [3:0]     cmd_imm,
  output logic           done,
  output logic [3:0]     result,
  output logic [3:0]     flags,
  input  logic [RAW-1:0] rd_addr,
  output logic [3:0]     rd_data
);

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [RAW-1:0] dst_q, dst_d, sa_q, sa_d, sb_q, sb_d;
  logic [3:0]     imm_q, imm_d;
  logic [3:0]     opa_q, opa_d, opb_q, opb_d;
  logic [3:0]     alu_y_q, alu_y_d, alu_f_q, alu_f_d;
  logic [3:0]     result_q, result_d, flags_q, flags_d;
  logic           done_q, done_d;

  logic           we;
  logic [3:0]     wdata;
  logic [3:0]     ra_data, rb_data;
  logic [3:0]     alu_y;
  logic           alu_c, alu_n, alu_z, alu_v;

  regfile4 #(.NREG(NREG), .RAW(RAW)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (dst_q),
    .wdata   (wdata),
    .ra_addr (sa_q),
    .ra_data (ra_data),
    .rb_addr (sb_q),
    .rb_data (rb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ALU sees only registered operands and opcode, so its inputs are stable in EXEC.
  alu4 u_alu (
    .a  (opa_q),
    .b  (opb_q),
    .op (op_q[2:0]),
    .y  (alu_y),
    .c  (alu_c),
    .n  (alu_n),
    .z  (alu_z),
    .v  (alu_v)
  );

  // Next-state and outputs: hold everything by default, each state updates its own part.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    alu_y_d   = alu_y_q;
    alu_f_d   = alu_f_q;
    result_d  = result_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    we        = 1'b0;
    wdata     = 4'd0;
    cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          sa_d    = cmd_sa;
          sb_d    = cmd_sb;
          imm_d   = cmd_imm;
          state_d = cmd_op[LOADI_BIT] ? WB : FETCH;
        end
      end
      FETCH: begin
        opa_d   = ra_data;
        opb_d   = rb_data;
        state_d = EXEC;
      end
      EXEC: begin
        alu_y_d = alu_y;
        alu_f_d = {alu_c, alu_n, alu_z, alu_v};
        state_d = WB;
      end
      WB: begin
        we       = 1'b1;
        wdata    = op_q[LOADI_BIT] ? imm_q : alu_y_q;
        result_d = wdata;
        // LOADI leaves flags alone; ALU ops copy the captured flags unchanged.
        if (!op_q[LOADI_BIT]) flags_d = alu_f_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      alu_y_q  <= '0;
      alu_f_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      alu_y_q  <= alu_y_d;
      alu_f_q  <= alu_f_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu4_ctrl.sv
// Scoreboard bench for alu4_ctrl: the stimulus pushes expected write-backs,
// a monitor pops and compares on every done pulse.
module tb_alu4_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dst, cmd_sa, cmd_sb;
  logic [3:0] cmd_imm;
  logic       done;
  logic [3:0] result, flags;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;

  alu4_ctrl #(.NREG(4), .RAW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_sa    (cmd_sa),
    .cmd_sb    (cmd_sb),
    .cmd_imm   (cmd_imm),
    .done      (done),
    .result    (result),
    .flags     (flags),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic [3:0] flg;
    logic [3:0] msk;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] LDI  = 4'b1000;
  localparam logic [3:0] NOTA = 4'b0000;
  localparam logic [3:0] ANDO = 4'b0010;
  localparam logic [3:0] XORO = 4'b0100;
  localparam logic [3:0] SUBO = 4'b0110;
  localparam logic [3:0] ADDO = 4'b0111;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("done_without_cmd", int'(done), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, int'(result), int'(e.res));
        check({e.name, "_flags"}, int'(flags & e.msk), int'(e.flg));
      end
    end
  end

  task automatic push_exp(input logic [3:0] res, input logic [3:0] flg,
                          input logic [3:0] msk, input string name);
    exp_t e;
    e.res = res; e.flg = flg; e.msk = msk; e.name = name;
    sb_q.push_back(e);
  endtask

  // Drive a command and return after the accepting edge (called at a negedge).
  task automatic issue(input logic [3:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic [3:0] imm, output int waited);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb; cmd_imm = imm;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("accept_timeout", int'(cmd_ready), 1);
    @(posedge clk);
  endtask

  // Count negedges from acceptance to done; cmd_ready must stay low meanwhile.
  task automatic wait_done(input int exp_lat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (done !== 1'b1) check({name, "_busy_ready"}, int'(cmd_ready), 0);
    end while (done !== 1'b1 && n < 10);
    check({name, "_latency"}, n, exp_lat);
  endtask

  task automatic rd_check(input logic [1:0] addr, input logic [3:0] exp, input string name);
    rd_addr = addr;
    #1;
    check({name, "_rd"}, int'(rd_data), int'(exp));
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [3:0] imm, input logic [3:0] res,
                         input logic [3:0] flg, input logic [3:0] msk,
                         input string name);
    int w;
    push_exp(res, flg, msk, name);
    issue(op, dst, sa, sb, imm, w);
    #1;
    // Fields change to junk after acceptance; only the latched copy matters.
    cmd_valid = 1'b0;
    cmd_op = 4'b0101; cmd_dst = ~dst; cmd_sa = ~sa; cmd_sb = ~sb; cmd_imm = ~imm;
    wait_done(op[3] ? 2 : 4, name);
    rd_check(dst, res, name);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    rd_addr = 2'd0;
    // A command offered during reset must be ignored.
    cmd_valid = 1'b1; cmd_op = LDI; cmd_dst = 2'd2; cmd_sa = 2'd0; cmd_sb = 2'd0; cmd_imm = 4'hC;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b0;
    check("rst_result", int'(result), 0);
    check("rst_flags", int'(flags), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 1);
    for (int i = 0; i < 4; i++) rd_check(2'(i), 4'h0, "rst_reg");

    run_cmd(LDI,  2'd0, 2'd0, 2'd0, 4'b0011, 4'b0011, 4'b0000, 4'b1111, "ldi_r0");
    run_cmd(LDI,  2'd1, 2'd0, 2'd0, 4'b0101, 4'b0101, 4'b0000, 4'b1111, "ldi_r1");
    rd_check(2'd0, 4'b0011, "r0_kept");
    run_cmd(XORO, 2'd2, 2'd0, 2'd1, 4'h0, 4'b0110, 4'b0000, 4'b0110, "xor");
    run_cmd(ADDO, 2'd3, 2'd0, 2'd1, 4'h0, 4'b1000, 4'b0101, 4'b1111, "add_ovf");
    run_cmd(SUBO, 2'd2, 2'd0, 2'd0, 4'h0, 4'b0000, 4'b0010, 4'b0110, "sub_zero");
    run_cmd(NOTA, 2'd1, 2'd1, 2'd0, 4'h0, 4'b1010, 4'b0100, 4'b0110, "nota");

    // Back-to-back with cmd_valid held: the AND must see the freshly loaded r0.
    push_exp(4'b1111, 4'b0100, 4'b0110, "ldi_f");
    push_exp(4'b1010, 4'b0100, 4'b0110, "and_raw");
    issue(LDI, 2'd0, 2'd0, 2'd0, 4'b1111, w);
    #1;
    cmd_op = ANDO; cmd_dst = 2'd2; cmd_sa = 2'd0; cmd_sb = 2'd1; cmd_imm = 4'h0;
    wait_done(2, "ldi_f");
    rd_check(2'd0, 4'b1111, "ldi_f");
    issue(ANDO, 2'd2, 2'd0, 2'd1, 4'h0, w);
    check("b2b_accept_wait", w, 0);
    #1;
    cmd_valid = 1'b0;
    wait_done(4, "and_raw");
    rd_check(2'd2, 4'b1010, "and_raw");

    // Carry out together with overflow: 1010 + 1010 = 1_0100.
    run_cmd(ADDO, 2'd3, 2'd1, 2'd1, 4'h0, 4'b0100, 4'b1001, 4'b1111, "add_carry");

    // Reset in the EXEC cycle abandons the add: no done, everything cleared.
    issue(ADDO, 2'd3, 2'd0, 2'd1, 4'h0, w);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);          // FETCH
    @(negedge clk);          // EXEC
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_done", int'(done), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_flags", int'(flags), 0);
    for (int i = 0; i < 4; i++) rd_check(2'(i), 4'h0, "midrst_reg");
    @(negedge clk);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_no_done", int'(done), 0);
    repeat (4) @(negedge clk);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
